// File: rtl/llr_frame_loader_pkg.sv
// Shared constants and types for the LDPC intrinsic-LLR frame loader.
//   L             circulant size / words per PE memory
//   K             block rows/cols; PE_COUNT = K*K processing elements
//   FRAME_LEN     intrinsic messages per frame (L*K*K)
//   ADDR_WIDTH    PE memory address width (log2(L))
//   MESSAGE_WIDTH intrinsic LLR width
//   loader_state_t  loader FSM states
package ldpc_pkg;

  localparam int unsigned L             = 32;
  localparam int unsigned K             = 6;
  localparam int unsigned PE_COUNT      = K * K;
  localparam int unsigned FRAME_LEN     = L * PE_COUNT;
  localparam int unsigned ADDR_WIDTH    = 5;
  localparam int unsigned MESSAGE_WIDTH = 5;
  localparam int unsigned CLR_CYCLES    = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/llr_frame_loader_if.sv
// Valid/ready LLR stream feeding the frame loader.
//   s_valid  beat valid (source -> loader)
//   s_ready  loader accepts beat (loader -> source)
//   s_data   LLR value
//   s_last   final beat of frame
// master: stream source; slave: the loader.
interface llr_frame_loader_if #(
  parameter int unsigned MESSAGE_WIDTH = ldpc_pkg::MESSAGE_WIDTH
);

  logic                     s_valid;
  logic                     s_ready;
  logic [MESSAGE_WIDTH-1:0] s_data;
  logic                     s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/llr_frame_loader_pe_addr_counter.sv
// Write-position counters for the frame loader.
// addr_cnt walks 0..L-1 inside one PE memory; pe_idx advances when addr_cnt
// wraps and walks 0..PE_COUNT-1. last_beat flags the final position of a frame.
//   clk, rst_n  clock, async active-low reset
//   inc         advance one position (accepted beat)
//   clr         return both counters to 0 (frame end); wins over inc
//   addr_cnt    current PE memory address
//   pe_idx      current PE index
//   last_beat   current position is the last one of the frame
module pe_addr_counter #(
  parameter int unsigned L          = ldpc_pkg::L,
  parameter int unsigned PE_COUNT   = ldpc_pkg::PE_COUNT,
  parameter int unsigned ADDR_WIDTH = ldpc_pkg::ADDR_WIDTH,
  parameter int unsigned IDX_WIDTH  = $clog2(ldpc_pkg::PE_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] addr_cnt,
  output logic [IDX_WIDTH-1:0]  pe_idx,
  output logic                  last_beat
);

  import ldpc_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(L - 1);
  localparam logic [IDX_WIDTH-1:0]  IDX_MAX  = IDX_WIDTH'(PE_COUNT - 1);

  logic addr_wrap;

  always_comb begin
    addr_wrap = (addr_cnt == ADDR_MAX);
    last_beat = addr_wrap && (pe_idx == IDX_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
      pe_idx   <= '0;
    end else if (clr) begin
      addr_cnt <= '0;
      pe_idx   <= '0;
    end else if (inc) begin
      if (addr_wrap) begin
        addr_cnt <= '0;
        pe_idx   <= (pe_idx == IDX_MAX) ? '0 : pe_idx + 1'b1;
      end else begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/llr_frame_loader.sv
// Upstream feeder for the LDPC decoder: takes one frame of channel LLRs over a
// valid/ready stream and writes them into the decoder's PE memories.
// A frame is cleared (ext_reset) and loaded only after the decoder signals
// completion of the previous one by toggling f_id.
//   clk           system clock
//   reset         asynchronous active-low reset
//   stream        LLR stream (slave side): s_valid/s_ready/s_data/s_last
//   f_id          decoder frame id, toggles when a decode finishes
//   ext_reset     decoder clear strobe, CLR_CYCLES long
//   en            decoder enable, set after the first clear, held until reset
//   pe_select     one-hot PE write select, all-zero = no write
//   load_add_in   PE memory address of the write
//   int_in        intrinsic data of the write
//   frame_loaded  one-cycle pulse with the final write of a frame
//   len_err       sticky frame-length error
module llr_frame_loader #(
  parameter int unsigned L             = ldpc_pkg::L,
  parameter int unsigned K             = ldpc_pkg::K,
  parameter int unsigned ADDR_WIDTH    = ldpc_pkg::ADDR_WIDTH,
  parameter int unsigned MESSAGE_WIDTH = ldpc_pkg::MESSAGE_WIDTH,
  parameter int unsigned CLR_CYCLES    = ldpc_pkg::CLR_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  llr_frame_loader_if.slave        stream,
  input  logic                     f_id,
  output logic                     ext_reset,
  output logic                     en,
  output logic [K*K-1:0]           pe_select,
  output logic [ADDR_WIDTH-1:0]    load_add_in,
  output logic [MESSAGE_WIDTH-1:0] int_in,
  output logic                     frame_loaded,
  output logic                     len_err
);

  import ldpc_pkg::*;

  localparam int unsigned PE_CNT    = K * K;
  localparam int unsigned IDX_WIDTH = $clog2(PE_CNT);
  localparam int unsigned CLR_WIDTH = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [CLR_WIDTH-1:0] CLR_LAST = CLR_WIDTH'(CLR_CYCLES - 1);
  localparam logic [PE_CNT-1:0]    PE_ONE   = {{(PE_CNT-1){1'b0}}, 1'b1};

  loader_state_t state, state_nxt;

  logic [CLR_WIDTH-1:0]  clr_cnt;
  logic                  ref_fid;
  logic                  done_seen;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [IDX_WIDTH-1:0]  pe_idx;
  logic                  last_beat;

  logic s_ready_c;
  logic accept;
  logic frame_end;
  logic clear_done;

  pe_addr_counter #(
    .L          (L),
    .PE_COUNT   (PE_CNT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_pe_addr_counter (
    .clk       (clk),
    .rst_n     (reset),
    .inc       (accept),
    .clr       (frame_end),
    .addr_cnt  (addr_cnt),
    .pe_idx    (pe_idx),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Beats are only ever accepted while in LOAD; the frame-ending beat moves
  // the FSM out of LOAD so s_ready drops on the very next cycle.
  always_comb begin
    state_nxt  = state;
    s_ready_c  = 1'b0;
    ext_reset  = 1'b0;
    accept     = 1'b0;
    frame_end  = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (stream.s_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        ext_reset = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          clear_done = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        s_ready_c = 1'b1;
        accept    = stream.s_valid;
        frame_end = accept && (stream.s_last || last_beat);
        if (frame_end) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_seen) state_nxt = CLEAR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stream.s_ready = s_ready_c;

  // Control registers: clear timer, enable, frame-id reference and the
  // remembered decode-complete event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt   <= '0;
      en        <= 1'b0;
      ref_fid   <= 1'b0;
      done_seen <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      if (state == CLEAR && !clear_done) clr_cnt <= clr_cnt + 1'b1;
      else                               clr_cnt <= '0;

      if (clear_done) begin
        en      <= 1'b1;
        ref_fid <= f_id;
      end

      // A toggle seen during LOAD is held here until WAIT_DONE consumes it.
      if (state == WAIT_DONE && done_seen)
        done_seen <= 1'b0;
      else if ((state == LOAD || state == WAIT_DONE) && (f_id != ref_fid))
        done_seen <= 1'b1;

      // Length error: s_last early, or missing on the final position.
      if (accept && (stream.s_last != last_beat)) len_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_select    <= '0;
      load_add_in  <= '0;
      int_in       <= '0;
      frame_loaded <= 1'b0;
    end else begin
      frame_loaded <= frame_end;
      if (accept) begin
        pe_select   <= PE_ONE << pe_idx;
        load_add_in <= addr_cnt;
        int_in      <= stream.s_data;
      end else begin
        pe_select   <= '0;
      end
    end
  end

endmodule
